// File: rtl/ecpri_rx_parse.sv
// eCPRI receive-side parser for Remote Memory Access (message type 0x04).
// Walks the 4-byte common header and the 12-byte RMA header, forwards
// write-request data to the tx stage, and pulses a write or read response
// request when a frame is complete and self-consistent. Malformed, truncated
// or aborted frames end in a single hdr_err pulse.
// Optional build macro: ECPRI_RX_REVCHK_EN -- when defined, common-header
// byte 0 must carry revision 1 with the C (concatenation) bit clear.
module ecpri_rx_parse #(
  parameter int MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_sof,
  input  logic       rx_eof,
  output logic [7:0] rx_buff,
  output logic       rx_buff_valid,
  output logic [7:0] tx_payload_len,
  output logic       send_write_resp,
  output logic       send_read_resp,
  output logic       hdr_err
);

  typedef enum logic [2:0] {IDLE, CHDR, RMAHDR, DATA, DROP} state_t;

  state_t      state;
  logic [3:0]  hcnt;      // byte index inside CHDR / RMAHDR
  logic [7:0]  dcnt;      // data bytes forwarded in DATA
  logic        ovf;       // a data byte arrived beyond the declared length
  logic        is_wr;     // RMA R/W field, 1 = write
  logic [15:0] psize;     // common-header payload size
  logic [7:0]  len_hi;    // RMA data length, upper byte
  logic [7:0]  dlen;      // RMA data length (bounded by MAX_LEN <= 255)

  logic        rev_bad;
  logic [15:0] len_w;
  logic        dfwd;
  logic [7:0]  dcnt_next;
  logic        ovf_next;

`ifdef ECPRI_RX_REVCHK_EN
  assign rev_bad = (rx_data[7:4] != 4'h1) || rx_data[0];
`else
  assign rev_bad = 1'b0;
`endif

  assign len_w     = {len_hi, rx_data};
  assign dfwd      = (dcnt < dlen);
  assign dcnt_next = dfwd ? dcnt + 8'd1 : dcnt;
  assign ovf_next  = ovf | ~dfwd;

  // Frame walker: header decode, data forwarding and end-of-frame verdict.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      hcnt            <= '0;
      dcnt            <= '0;
      ovf             <= 1'b0;
      is_wr           <= 1'b0;
      psize           <= '0;
      len_hi          <= '0;
      dlen            <= '0;
      rx_buff         <= '0;
      rx_buff_valid   <= 1'b0;
      tx_payload_len  <= '0;
      send_write_resp <= 1'b0;
      send_read_resp  <= 1'b0;
      hdr_err         <= 1'b0;
    end else begin
      rx_buff_valid   <= 1'b0;
      send_write_resp <= 1'b0;
      send_read_resp  <= 1'b0;
      hdr_err         <= 1'b0;
      if (rx_valid) begin
        if (rx_sof) begin
          // A new frame always restarts the walk; an unfinished frame is
          // reported here unless it was already reported on entry to DROP.
          hdr_err <= ((state != IDLE) && (state != DROP)) || rev_bad || rx_eof;
          hcnt    <= 4'd1;
          dcnt    <= '0;
          ovf     <= 1'b0;
          if (rx_eof)       state <= IDLE;
          else if (rev_bad) state <= DROP;
          else              state <= CHDR;
        end else begin
          case (state)
            CHDR: begin
              hcnt <= hcnt + 4'd1;
              if (hcnt == 4'd2) psize[15:8] <= rx_data;
              if (hcnt == 4'd3) begin
                psize[7:0] <= rx_data;
                hcnt       <= '0;
                state      <= RMAHDR;
              end
              if (rx_eof) begin
                hdr_err <= 1'b1;
                state   <= IDLE;
              end else if ((hcnt == 4'd1) && (rx_data != 8'h04)) begin
                hdr_err <= 1'b1;
                state   <= DROP;
              end
            end
            RMAHDR: begin
              hcnt <= hcnt + 4'd1;
              if (hcnt == 4'd1)  is_wr  <= rx_data[4];
              if (hcnt == 4'd10) len_hi <= rx_data;
              if ((hcnt == 4'd1) && ((rx_data[7:5] != 3'd0) || (rx_data[3:0] != 4'd0))) begin
                hdr_err <= 1'b1;
                state   <= rx_eof ? IDLE : DROP;
              end else if (hcnt == 4'd11) begin
                dlen <= len_w[7:0];
                if ((len_w > 16'(MAX_LEN)) || (is_wr && (len_w == 16'd0))) begin
                  hdr_err <= 1'b1;
                  state   <= rx_eof ? IDLE : DROP;
                end else if (is_wr) begin
                  // A write whose header ends the frame carries no data.
                  hdr_err <= rx_eof;
                  state   <= rx_eof ? IDLE : DATA;
                end else if (!rx_eof) begin
                  // Reads carry no data; anything after the header is junk.
                  hdr_err <= 1'b1;
                  state   <= DROP;
                end else begin
                  state <= IDLE;
                  if (psize == 16'd12) begin
                    send_read_resp <= 1'b1;
                    tx_payload_len <= len_w[7:0];
                  end else begin
                    hdr_err <= 1'b1;
                  end
                end
              end else if (rx_eof) begin
                hdr_err <= 1'b1;
                state   <= IDLE;
              end
            end
            DATA: begin
              if (dfwd) begin
                rx_buff       <= rx_data;
                rx_buff_valid <= 1'b1;
              end
              dcnt <= dcnt_next;
              ovf  <= ovf_next;
              if (rx_eof) begin
                state <= IDLE;
                if (!ovf_next && (dcnt_next == dlen) &&
                    (psize == 16'd12 + {8'd0, dcnt_next}))
                  send_write_resp <= 1'b1;
                else
                  hdr_err <= 1'b1;
              end
            end
            DROP: begin
              if (rx_eof) state <= IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
